// File: rtl/hub75_row_driver.sv
// HUB75 transmit-side row driver: fetches a top/bottom row pair, shifts it out
// column by column, then blanks, latches and displays it while walking every row address.
module hub75_row_driver #(
  parameter int NUM_COLS       = 64,
  parameter int NUM_ROWS       = 32,
  parameter int ADDR_W         = 4,
  parameter int BLANK_CYCLES   = 2,
  parameter int DISPLAY_CYCLES = 64
) (
  input  logic                  bclk,
  input  logic                  n_reset,
  input  logic                  enable,
  output logic                  row_req,
  output logic [ADDR_W-1:0]     row_addr,
  input  logic                  row_valid,
  input  logic [3*NUM_COLS-1:0] row_top,
  input  logic [3*NUM_COLS-1:0] row_bot,
  output logic [2:0]            rgb_top,
  output logic [2:0]            rgb_bot,
  output logic                  sclk_en,
  output logic [ADDR_W-1:0]     addr,
  output logic                  oe,
  output logic                  le,
  output logic                  frame_done
);

  localparam int MAX_A   = (NUM_COLS > BLANK_CYCLES) ? NUM_COLS : BLANK_CYCLES;
  localparam int MAX_CNT = (MAX_A > DISPLAY_CYCLES) ? MAX_A : DISPLAY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]  LAST_COL   = CNT_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0]  LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_DISP  = CNT_W'(DISPLAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(NUM_ROWS / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [ADDR_W-1:0]            row_cnt;
  logic [ADDR_W-1:0]            row_next;
  logic [2:0][NUM_COLS-1:0]     sr_top;
  logic [2:0][NUM_COLS-1:0]     sr_bot;

  // Plane index 0 is red, 1 green, 2 blue; the MSB of each plane is the next column out.
  function automatic logic [2:0] col_msbs(input logic [2:0][NUM_COLS-1:0] v);
    return {v[2][NUM_COLS-1], v[1][NUM_COLS-1], v[0][NUM_COLS-1]};
  endfunction

  function automatic logic [2:0][NUM_COLS-1:0] shl(input logic [2:0][NUM_COLS-1:0] v);
    logic [2:0][NUM_COLS-1:0] r;
    for (int c = 0; c < 3; c++) r[c] = {v[c][NUM_COLS-2:0], 1'b0};
    return r;
  endfunction

  always_comb begin
    row_next = (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
  end

  always_ff @(posedge bclk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      row_cnt    <= '0;
      sr_top     <= '0;
      sr_bot     <= '0;
      row_req    <= 1'b0;
      row_addr   <= '0;
      rgb_top    <= 3'b000;
      rgb_bot    <= 3'b000;
      sclk_en    <= 1'b0;
      addr       <= '0;
      oe         <= 1'b1;
      le         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= LOAD;
            row_cnt  <= '0;
            row_req  <= 1'b1;
            row_addr <= '0;
          end
        end

        // The first column leaves straight from the bus so the shift starts next cycle.
        LOAD: begin
          if (row_valid) begin
            state   <= SHIFT;
            row_req <= 1'b0;
            sr_top  <= shl(row_top);
            sr_bot  <= shl(row_bot);
            rgb_top <= col_msbs(row_top);
            rgb_bot <= col_msbs(row_bot);
            sclk_en <= 1'b1;
            cnt     <= '0;
          end
        end

        SHIFT: begin
          if (cnt == LAST_COL) begin
            state   <= BLANK;
            sclk_en <= 1'b0;
            rgb_top <= 3'b000;
            rgb_bot <= 3'b000;
            addr    <= row_cnt;
            cnt     <= '0;
          end else begin
            cnt     <= cnt + 1'b1;
            rgb_top <= col_msbs(sr_top);
            rgb_bot <= col_msbs(sr_bot);
            sr_top  <= shl(sr_top);
            sr_bot  <= shl(sr_bot);
          end
        end

        BLANK: begin
          if (cnt == LAST_BLANK) begin
            state <= LATCH;
            le    <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        LATCH: begin
          state <= DISPLAY;
          le    <= 1'b0;
          oe    <= 1'b0;
          cnt   <= '0;
        end

        // End of display: decide between the next row and going idle, with the counter wrapping per frame.
        DISPLAY: begin
          if (cnt == LAST_DISP) begin
            oe  <= 1'b1;
            cnt <= '0;
            if (row_cnt == LAST_ROW) frame_done <= 1'b1;
            if (enable) begin
              state    <= LOAD;
              row_cnt  <= row_next;
              row_req  <= 1'b1;
              row_addr <= row_next;
            end else begin
              state    <= IDLE;
              row_cnt  <= '0;
              row_addr <= '0;
              addr     <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_row_driver.sv
// Scoreboard bench for hub75_row_driver: the row source pushes each transferred row,
// a panel-side monitor rebuilds the shifted row and pops/compares on every latch pulse.
module tb_hub75_row_driver;

  localparam int N          = 64;
  localparam int BLANK      = 2;
  localparam int DISP       = 64;
  localparam int ROW_PERIOD = 1 + N + BLANK + 1 + DISP;

  logic            bclk = 1'b0;
  logic            n_reset;
  logic            enable;
  logic            row_req;
  logic [3:0]      row_addr;
  logic            row_valid;
  logic [3*N-1:0]  row_top;
  logic [3*N-1:0]  row_bot;
  logic [2:0]      rgb_top;
  logic [2:0]      rgb_bot;
  logic            sclk_en;
  logic [3:0]      addr;
  logic            oe;
  logic            le;
  logic            frame_done;

  typedef struct {
    logic [3:0]     a;
    logic [3*N-1:0] top;
    logic [3*N-1:0] bot;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = 0;
  int req_delay = 0;
  logic valid_tied = 1'b1;
  logic [3:0] exp_row = 4'd0;

  int le_count = 0;
  int fd_count = 0;
  int last_le_cyc = 0;
  int last_le_addr = 0;
  logic last_le_valid = 1'b0;
  logic period_on = 1'b0;
  int shift_cnt = 0;
  int last_req_run = 0;

  hub75_row_driver #(
    .NUM_COLS(N), .NUM_ROWS(32), .ADDR_W(4), .BLANK_CYCLES(BLANK), .DISPLAY_CYCLES(DISP)
  ) dut (
    .bclk(bclk), .n_reset(n_reset), .enable(enable),
    .row_req(row_req), .row_addr(row_addr), .row_valid(row_valid),
    .row_top(row_top), .row_bot(row_bot),
    .rgb_top(rgb_top), .rgb_bot(rgb_bot), .sclk_en(sclk_en),
    .addr(addr), .oe(oe), .le(le), .frame_done(frame_done)
  );

  always #5 bclk = ~bclk;

  initial forever begin
    @(posedge bclk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [3*N-1:0] actual, input logic [3*N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Layout is {blue, green, red}; mode 0 is the single-row corner-pixel pattern.
  function automatic logic [3*N-1:0] makeTop(input logic [3:0] r);
    if (mode == 0) return {128'h0, 64'h8000_0000_0000_0001};
    return {64'h0123_4567_89ab_cdef ^ {16{r}}, {16{~r}}, {16{r}}};
  endfunction

  function automatic logic [3*N-1:0] makeBot(input logic [3:0] r);
    if (mode == 0) return '0;
    return {{16{r}}, 64'h0, {16{r ^ 4'h5}}};
  endfunction

  task automatic applyStimulus(input logic en, input logic tied, input int dly, input int md);
    @(negedge bclk);
    valid_tied = tied;
    req_delay  = dly;
    mode       = md;
    exp_row    = 4'd0;
    enable     = en;
  endtask

  task automatic waitLe(input int target, input int budget, input string name);
    int n = 0;
    while (le_count < target && n < budget) begin
      @(negedge bclk);
      n++;
    end
    checkValue(name, int'(le_count >= target), 1);
  endtask

  // Upstream frame buffer: answers row_req after req_delay cycles, pushing the expected row on transfer.
  initial begin
    int  req_wait;
    logic valid_now;
    req_wait  = 0;
    row_valid = 1'b0;
    row_top   = '0;
    row_bot   = '0;
    forever begin
      @(negedge bclk);
      if (row_req) begin
        valid_now = valid_tied || (req_wait >= req_delay);
        req_wait++;
      end else begin
        valid_now = valid_tied;
        req_wait  = 0;
      end
      row_valid = valid_now;
      row_top   = makeTop(exp_row);
      row_bot   = makeBot(exp_row);
      if (row_req && valid_now && n_reset) begin
        checkValue("row_addr", int'(row_addr), int'(exp_row));
        sb.push_back('{a: exp_row, top: makeTop(exp_row), bot: makeBot(exp_row)});
        exp_row = exp_row + 4'd1;
      end
    end
  end

  // Panel-side monitor: rebuilds shifted rows and checks timing invariants each cycle.
  initial begin
    logic [2:0][N-1:0] cap_top;
    logic [2:0][N-1:0] cap_bot;
    logic prev_le, prev_oe, prev_req, prev_sclk;
    logic [3:0] prev_addr;
    int oe_run, req_run;
    exp_t e;
    cap_top = '0; cap_bot = '0;
    prev_le = 1'b0; prev_oe = 1'b1; prev_req = 1'b0; prev_sclk = 1'b0;
    prev_addr = 4'd0; oe_run = 0; req_run = 0;
    forever begin
      @(negedge bclk);
      if (!n_reset) begin
        shift_cnt = 0;
        prev_le = 1'b0; prev_oe = 1'b1; prev_req = 1'b0; prev_sclk = 1'b0;
        oe_run = 0; req_run = 0;
      end else begin
        if (sclk_en) begin
          if (!prev_sclk) checkValue("shift_after_xfer", int'(prev_req), 1);
          checkValue("oe_during_shift", int'(oe), 1);
          for (int c = 0; c < 3; c++) begin
            cap_top[c] = {cap_top[c][N-2:0], rgb_top[c]};
            cap_bot[c] = {cap_bot[c][N-2:0], rgb_bot[c]};
          end
          shift_cnt++;
        end
        if (le) begin
          checkValue("le_width", int'(prev_le), 0);
          checkValue("oe_at_le", int'(oe), 1);
          checkValue("blank_before_le", int'(oe_run >= 2), 1);
          checkValue("shift_count", shift_cnt, N);
          checkValue("sb_nonempty", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkValue("le_addr", int'(addr), int'(e.a));
            checkOutput("row_top_data", cap_top, e.top);
            checkOutput("row_bot_data", cap_bot, e.bot);
          end
          if (period_on && last_le_valid) checkValue("row_period", cyc - last_le_cyc, ROW_PERIOD);
          last_le_valid = 1'b1;
          last_le_cyc   = cyc;
          last_le_addr  = int'(addr);
          le_count++;
          shift_cnt = 0;
        end
        if (!oe && !prev_oe) checkValue("addr_stable", int'(addr), int'(prev_addr));
        if (frame_done) begin
          fd_count++;
          checkValue("frame_done_timing", cyc - last_le_cyc, DISP + 1);
          checkValue("frame_done_row", last_le_addr, 15);
        end
        if (row_req) req_run++;
        else if (prev_req) begin
          last_req_run = req_run;
          req_run = 0;
        end
        oe_run    = oe ? oe_run + 1 : 0;
        prev_le   = le;
        prev_oe   = oe;
        prev_addr = addr;
        prev_req  = row_req;
        prev_sclk = sclk_en;
      end
    end
  end

  initial begin
    int le_start, fd_start, n;
    n_reset = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge bclk);
    checkValue("rst_oe", int'(oe), 1);
    checkValue("rst_le", int'(le), 0);
    checkValue("rst_sclk_en", int'(sclk_en), 0);
    checkValue("rst_row_req", int'(row_req), 0);
    checkValue("rst_addr", int'(addr), 0);
    checkValue("rst_frame_done", int'(frame_done), 0);
    n_reset = 1'b1;
    repeat (3) @(negedge bclk);
    checkValue("idle_row_req", int'(row_req), 0);

    $display("[TB] single row, corner pixels");
    le_start = le_count;
    applyStimulus(1'b1, 1'b1, 0, 0);
    waitLe(le_start + 1, 400, "single_row_le");
    enable = 1'b0;
    repeat (300) @(negedge bclk);
    checkValue("single_row_les", le_count - le_start, 1);

    $display("[TB] full frame");
    le_start = le_count;
    fd_start = fd_count;
    last_le_valid = 1'b0;
    period_on = 1'b1;
    applyStimulus(1'b1, 1'b1, 0, 1);
    n = 0;
    while (fd_count == fd_start && n < 2500) begin
      @(negedge bclk);
      n++;
    end
    checkValue("frame_les", le_count - le_start, 16);
    enable = 1'b0;
    repeat (300) @(negedge bclk);
    period_on = 1'b0;
    checkValue("frame_done_once", fd_count - fd_start, 1);

    $display("[TB] delayed row_valid");
    le_start = le_count;
    applyStimulus(1'b1, 1'b0, 10, 1);
    waitLe(le_start + 1, 600, "delay_le");
    enable = 1'b0;
    checkValue("req_high_cycles", last_req_run, 11);
    repeat (300) @(negedge bclk);

    $display("[TB] enable dropped during row 3");
    le_start = le_count;
    applyStimulus(1'b1, 1'b1, 0, 1);
    n = 0;
    while (!(row_addr == 4'd3 && sclk_en) && n < 1000) begin
      @(negedge bclk);
      n++;
    end
    checkValue("reached_row3_shift", int'(row_addr == 4'd3 && sclk_en), 1);
    repeat (5) @(negedge bclk);
    enable = 1'b0;
    repeat (300) @(negedge bclk);
    checkValue("drop_les", le_count - le_start, 4);
    checkValue("drop_last_row", last_le_addr, 3);
    checkValue("drop_idle_oe", int'(oe), 1);
    checkValue("drop_idle_req", int'(row_req), 0);
    le_start = le_count;
    applyStimulus(1'b1, 1'b1, 0, 1);
    waitLe(le_start + 1, 400, "restart_le");
    enable = 1'b0;
    repeat (300) @(negedge bclk);

    $display("[TB] reset during shift");
    applyStimulus(1'b1, 1'b1, 0, 1);
    n = 0;
    while (shift_cnt < 20 && n < 400) begin
      @(negedge bclk);
      n++;
    end
    checkValue("reached_shift20", int'(shift_cnt >= 20), 1);
    @(posedge bclk);
    #2 n_reset = 1'b0;
    #1;
    checkValue("async_oe", int'(oe), 1);
    checkValue("async_le", int'(le), 0);
    checkValue("async_sclk_en", int'(sclk_en), 0);
    checkValue("async_row_req", int'(row_req), 0);
    checkValue("async_rgb_top", int'(rgb_top), 0);
    sb.delete();
    exp_row = 4'd0;
    repeat (3) @(negedge bclk);
    le_start = le_count;
    n_reset = 1'b1;
    waitLe(le_start + 1, 400, "post_reset_le");
    enable = 1'b0;
    repeat (300) @(negedge bclk);
    checkValue("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
